// File: rtl/nonce_collector_if.sv
// Bundles the serial nonce source side and the parallel nonce sink side of nonce_collector.
// ovf_count exists only when COLLECTOR_OVF_CNT_EN is defined.
interface nonce_collector_if;
  logic        newnonce;
  logic        nonce_i;
  logic        overflow_i;
  logic        read;
  logic [31:0] nonce_o;
  logic        nonce_valid;
  logic        nonce_ready;
`ifdef COLLECTOR_OVF_CNT_EN
  logic [15:0] ovf_count;

  modport master (
    output newnonce, nonce_i, overflow_i, nonce_ready,
    input  read, nonce_o, nonce_valid, ovf_count
  );
  modport slave (
    input  newnonce, nonce_i, overflow_i, nonce_ready,
    output read, nonce_o, nonce_valid, ovf_count
  );
`else
  modport master (
    output newnonce, nonce_i, overflow_i, nonce_ready,
    input  read, nonce_o, nonce_valid
  );
  modport slave (
    input  newnonce, nonce_i, overflow_i, nonce_ready,
    output read, nonce_o, nonce_valid
  );
`endif
endinterface

// File: rtl/nonce_collector.sv
// Collects 32-bit nonces from a serial source (LSB first) into a valid/ready output register.
// Optional saturating overflow counter enabled by COLLECTOR_OVF_CNT_EN.
module nonce_collector (
  input logic              clk,
  input logic              rst,
  nonce_collector_if.slave bus
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state, state_nxt;
  logic [4:0]  bit_cnt;
  logic [31:0] shreg;
  logic [31:0] nonce_q;
  logic        valid_q;
  logic        read_block;  // suppresses read for one IDLE cycle after reset or a SHIFT exit
  logic        start;
  logic        last;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (!read_block && bus.newnonce && (!valid_q || bus.nonce_ready)) begin
          start     = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_cnt == 5'd31) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= 5'd0;
      shreg      <= 32'd0;
      read_block <= 1'b1;
    end else begin
      state      <= state_nxt;
      read_block <= last;
      // Bit 0 arrives in the read cycle, so sampling starts there; the counter wraps 31->0 at exit.
      if (start || state == SHIFT) begin
        shreg[bit_cnt] <= bus.nonce_i;
        bit_cnt        <= bit_cnt + 5'd1;
      end
    end
  end

  // Output register: a finished word always lands; otherwise a handshake drops valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nonce_q <= 32'd0;
      valid_q <= 1'b0;
    end else if (last) begin
      nonce_q <= {bus.nonce_i, shreg[30:0]};
      valid_q <= 1'b1;
    end else if (valid_q && bus.nonce_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.read        = start;
  assign bus.nonce_o     = nonce_q;
  assign bus.nonce_valid = valid_q;

`ifdef COLLECTOR_OVF_CNT_EN
  logic [15:0] ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 16'd0;
    end else if (bus.overflow_i && ovf_q != 16'hFFFF) begin
      ovf_q <= ovf_q + 16'd1;
    end
  end

  assign bus.ovf_count = ovf_q;
`else
  logic ovf_unused;
  assign ovf_unused = bus.overflow_i;
`endif

endmodule

// File: tb/tb_nonce_collector.sv
// Directed bench for nonce_collector: reset, single transfer, backpressure, back-to-back,
// reset mid-shift and (with COLLECTOR_OVF_CNT_EN) the overflow counter.
module tb_nonce_collector;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  nonce_collector_if bus ();

  nonce_collector dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge; inputs change here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Caller has already driven newnonce=1 and nonce_i=word[0] for read cycle T.
  task automatic shift_word(input logic [31:0] word, input logic hold_new);
    #1;
    checks++;
    if (bus.read !== 1'b1) begin
      errors++;
      $display("FAIL read_at_T: got %b expected 1", bus.read);
    end
    for (int i = 1; i < 32; i++) begin
      step();
      bus.nonce_i  = word[i];
      bus.newnonce = hold_new;
      #1;
      checks++;
      if (bus.read !== 1'b0 || bus.nonce_valid !== 1'b0) begin
        errors++;
        $display("FAIL shift_bit%0d: got read=%b valid=%b expected read=0 valid=0",
                 i, bus.read, bus.nonce_valid);
      end
    end
    step();
    bus.nonce_i = 1'b0;
    #1;
    checks++;
    if (bus.nonce_valid !== 1'b1 || bus.nonce_o !== word || bus.read !== 1'b0) begin
      errors++;
      $display("FAIL word_at_T32: got valid=%b nonce=%h read=%b expected valid=1 nonce=%h read=0",
               bus.nonce_valid, bus.nonce_o, bus.read, word);
    end
  endtask

  task automatic test_reset();
    bus.newnonce    = 1'b1;
    bus.nonce_i     = 1'b1;
    bus.overflow_i  = 1'b0;
    bus.nonce_ready = 1'b0;
    step();
    step();
    checks++;
    if (bus.read !== 1'b0 || bus.nonce_valid !== 1'b0 || bus.nonce_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: got read=%b valid=%b nonce=%h expected 0 0 00000000",
               bus.read, bus.nonce_valid, bus.nonce_o);
    end
`ifdef COLLECTOR_OVF_CNT_EN
    checks++;
    if (bus.ovf_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_ovf: got %h expected 0000", bus.ovf_count);
    end
`endif
    rst = 1'b0;
    #1;
    checks++;
    if (bus.read !== 1'b0) begin
      errors++;
      $display("FAIL read_before_first_edge: got %b expected 0", bus.read);
    end
    bus.newnonce = 1'b0;
    step();
  endtask

  task automatic test_single();
    logic [31:0] w;
    w = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      step();
      #1;
      checks++;
      if (bus.read !== 1'b0) begin
        errors++;
        $display("FAIL idle_no_newnonce: got read=%b expected 0", bus.read);
      end
    end
    step();
    bus.newnonce = 1'b1;
    bus.nonce_i  = w[0];
    shift_word(w, 1'b0);
  endtask

  task automatic test_backpressure();
    logic [31:0] w;
    w = 32'h12345678;
    bus.nonce_ready = 1'b0;
    bus.newnonce    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      #1;
      checks++;
      if (bus.read !== 1'b0 || bus.nonce_valid !== 1'b1 || bus.nonce_o !== 32'hDEADBEEF) begin
        errors++;
        $display("FAIL backpressure_hold: got read=%b valid=%b nonce=%h expected 0 1 deadbeef",
                 bus.read, bus.nonce_valid, bus.nonce_o);
      end
    end
    step();
    bus.nonce_ready = 1'b1;
    bus.nonce_i     = w[0];
    shift_word(w, 1'b0);
    step();
    #1;
    checks++;
    if (bus.nonce_valid !== 1'b0) begin
      errors++;
      $display("FAIL valid_drop_after_accept: got %b expected 0", bus.nonce_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w0, w1;
    w0 = 32'h00000001;
    w1 = 32'h80000000;
    bus.nonce_ready = 1'b1;
    step();
    bus.newnonce = 1'b1;
    bus.nonce_i  = w0[0];
    shift_word(w0, 1'b1);
    step();
    bus.nonce_i = w1[0];
    #1;
    checks++;
    if (bus.nonce_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first_consumed: got %b expected 0", bus.nonce_valid);
    end
    shift_word(w1, 1'b1);
    bus.newnonce = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_shift();
    bus.nonce_ready = 1'b0;
    step();
    bus.newnonce = 1'b1;
    bus.nonce_i  = 1'b1;
    #1;
    checks++;
    if (bus.read !== 1'b1) begin
      errors++;
      $display("FAIL rms_start: got read=%b expected 1", bus.read);
    end
    for (int i = 1; i <= 17; i++) begin
      step();
      bus.newnonce = 1'b0;
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.read !== 1'b0 || bus.nonce_valid !== 1'b0 || bus.nonce_o !== 32'd0) begin
      errors++;
      $display("FAIL rms_reset: got read=%b valid=%b nonce=%h expected 0 0 00000000",
               bus.read, bus.nonce_valid, bus.nonce_o);
    end
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      #1;
      checks++;
      if (bus.read !== 1'b0 || bus.nonce_valid !== 1'b0) begin
        errors++;
        $display("FAIL rms_after: got read=%b valid=%b expected 0 0",
                 bus.read, bus.nonce_valid);
      end
    end
    step();
    bus.newnonce = 1'b1;
    bus.nonce_i  = 1'b1;
    shift_word(32'hA5A50F0F | 32'h1, 1'b0);
  endtask

`ifdef COLLECTOR_OVF_CNT_EN
  task automatic test_ovf_count();
    for (int i = 0; i < 3; i++) begin
      step();
      bus.overflow_i = 1'b1;
      step();
      bus.overflow_i = 1'b0;
    end
    step();
    checks++;
    if (bus.ovf_count !== 16'd3) begin
      errors++;
      $display("FAIL ovf_three: got %h expected 0003", bus.ovf_count);
    end
    bus.overflow_i = 1'b1;
    for (int i = 0; i < 70000; i++) step();
    bus.overflow_i = 1'b0;
    step();
    checks++;
    if (bus.ovf_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL ovf_saturate: got %h expected ffff", bus.ovf_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_shift();
`ifdef COLLECTOR_OVF_CNT_EN
    test_ovf_count();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
